// File: rtl/mul_iter_e.sv
// Iterative shift-add multiplier (MUL/MLA) for the execute stage, one multiplier bit per cycle.
// Optional early termination on an exhausted multiplier: define MUL_EARLY_TERM_EN.
module mul_iter_e #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StartE,
  input  logic             AccE,
  input  logic             KillE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic [WIDTH-1:0] SrcCE,
  output logic [WIDTH-1:0] MulResultE,
  output logic             MulValidE,
  output logic [1:0]       MulFlagsE,
  output logic             StallMulE,
  output logic             BusyE,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              start_ok;
  logic              last_iter;

  assign start_ok = StartE & ~KillE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    last_iter = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          a_d     = SrcAE;
          b_d     = SrcBE;
          acc_d   = AccE ? SrcCE : '0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d       = a_q << 1;
        b_d       = b_q >> 1;
        cnt_d     = cnt_q + CNTW'(1);
        last_iter = (cnt_q == CNTW'(WIDTH - 1));
`ifdef MUL_EARLY_TERM_EN
        // Remaining multiplier bits are all zero: further iterations add nothing.
        if (b_d == '0) last_iter = 1'b1;
`endif
        if (last_iter) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A flushed instruction must leave the accumulator untouched.
    if (KillE) begin
      state_d = S_IDLE;
      acc_d   = acc_q;
    end
  end

  assign MulResultE  = acc_q;
  assign MulValidE   = (state_q == S_DONE);
  assign MulFlagsE   = {acc_q[WIDTH-1], (acc_q == '0)};
  assign BusyE       = (state_q == S_BUSY);
  // Gated by reset so the stall drops at once even while StartE is still held.
  assign StallMulE   = ~reset & (((state_q == S_IDLE) & start_ok) | (state_q == S_BUSY));
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mul_iter_e.sv
// Self-checking bench for mul_iter_e: reference model from 64-bit arithmetic and multiplier bit-length.
// Handshake: a multiply is issued by holding StartE until MulValidE; MulValidE marks the single result cycle.
module tb_mul_iter_e;
  logic        clk = 1'b0;
  logic        reset;
  logic        StartE, AccE, KillE;
  logic [31:0] SrcAE, SrcBE, SrcCE;
  logic [31:0] MulResultE;
  logic        MulValidE;
  logic [1:0]  MulFlagsE;
  logic        StallMulE, BusyE;
  logic [1:0]  dbg_state_o;

  logic [33:0] exp_q[$];
  int          pass_cnt  = 0;
  int          total_cnt = 0;

`ifdef MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  mul_iter_e dut (
    .clk(clk), .reset(reset), .StartE(StartE), .AccE(AccE), .KillE(KillE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .SrcCE(SrcCE),
    .MulResultE(MulResultE), .MulValidE(MulValidE), .MulFlagsE(MulFlagsE),
    .StallMulE(StallMulE), .BusyE(BusyE), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int bitlen(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) if (v[i]) return i + 1;
    return 0;
  endfunction

  function automatic int exp_latency(input logic [31:0] b);
    int n;
    if (!EARLY) return 32;
    n = bitlen(b);
    return (n < 1) ? 1 : n;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    logic [33:0] e;
    if (MulValidE === 1'b1) begin
      if (exp_q.size() == 0) chk("valid_without_issue", {63'b0, MulValidE}, 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("result", {32'b0, MulResultE}, {32'b0, e[31:0]});
        chk("flags", {62'b0, MulFlagsE}, {62'b0, e[33:32]});
      end
    end
  end

  // driver: called just after a rising edge; returns just after a rising edge
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic acc);
    logic [63:0] full;
    logic [31:0] r;
    int          n_exp, cyc, stalls;
    bit          got;
    full = {32'b0, a} * {32'b0, b} + (acc ? {32'b0, c} : 64'd0);
    r = full[31:0];
    exp_q.push_back({r[31], (r == 32'd0), r});
    n_exp = exp_latency(b);
    SrcAE = a; SrcBE = b; SrcCE = c; AccE = acc; StartE = 1'b1;
    cyc = 0; stalls = 0; got = 1'b0;
    while (!got && cyc < 80) begin
      @(negedge clk);
      if (MulValidE === 1'b1) got = 1'b1;
      else begin
        if (StallMulE === 1'b1) stalls++;
        cyc++;
      end
    end
    chk("valid_seen", {63'b0, got}, 64'd1);
    if (!got) void'(exp_q.pop_back());
    else begin
      chk("latency", 64'(cyc), 64'(n_exp + 1));
      chk("stall_cycles", 64'(stalls), 64'(n_exp + 1));
      chk("stall_in_done", {63'b0, StallMulE}, 64'd0);
    end
    @(posedge clk); #1;
    StartE = 1'b0; AccE = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_result"}, {32'b0, MulResultE}, 64'd0);
    chk({tag, "_valid"}, {63'b0, MulValidE}, 64'd0);
    chk({tag, "_flags"}, {62'b0, MulFlagsE}, 64'd1);
    chk({tag, "_stall"}, {63'b0, StallMulE}, 64'd0);
    chk({tag, "_busy"}, {63'b0, BusyE}, 64'd0);
    chk({tag, "_state"}, {62'b0, dbg_state_o}, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, rc;
    reset = 1'b1; StartE = 1'b0; AccE = 1'b0; KillE = 1'b0;
    SrcAE = '0; SrcBE = '0; SrcCE = '0;
    @(negedge clk);
    chk_reset_values("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_mul(32'd7, 32'd6, 32'd0, 1'b0);
    run_mul(32'd3, 32'd5, 32'd10, 1'b1);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_mul(32'h8000_0000, 32'd1, 32'd0, 1'b0);
    run_mul(32'd5, 32'd0, 32'd0, 1'b0);
    run_mul(32'd0, 32'h1234_5678, 32'd0, 1'b1);

    // kill mid-BUSY at T+5
    SrcAE = 32'd11; SrcBE = 32'hFFFF_FFFF; AccE = 1'b0; StartE = 1'b1;
    repeat (5) @(posedge clk);
    #1 KillE = 1'b1;
    @(negedge clk);
    chk("busy_before_kill", {63'b0, BusyE}, 64'd1);
    @(posedge clk); #1;
    KillE = 1'b0; StartE = 1'b0;
    @(negedge clk);
    chk("kill_state_idle", {62'b0, dbg_state_o}, 64'd0);
    chk("kill_stall_low", {63'b0, StallMulE}, 64'd0);
    chk("kill_no_valid", {63'b0, MulValidE}, 64'd0);
    repeat (40) @(negedge clk);
    @(posedge clk); #1;

    // asynchronous reset mid-BUSY
    SrcAE = 32'd3; SrcBE = 32'h0000_FFFF; StartE = 1'b1;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1 chk_reset_values("async_reset");
    StartE = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_mul(32'd2, 32'd2, 32'd0, 1'b0);

    // randomized, mixing back-to-back issues with idle gaps
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      rc = $urandom;
      run_mul(ra, rb, rc, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/mul_iter_e.md
# mul_iter_e

Iterative shift-add multiplier for the execute stage: performs MUL and MLA as a multi-cycle operation, stalls the pipeline while busy, and presents a 32-bit result plus N/Z flags to the execute-stage result mux. It sits directly downstream of the controller. The controller issues `MulOpE`, the MUL/MLA selection (`ALUControlE` 4'b0100 / 4'b0101) and the conditional-execute qualification. The hazard unit consumes `StallMulE`.

## Interface
- `WIDTH`, default 32: operand and result width.
- `CNTW`, default 5: iteration counter width; must satisfy 2^CNTW = WIDTH.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `StartE` in 1: `MulOpE & CondExE`; high while a multiply occupies E.
- `AccE` in 1: 1 = MLA (add `SrcCE`), 0 = MUL.
- `KillE` in 1: abort; the E-stage instruction is being flushed.
- `SrcAE` in WIDTH: multiplicand (Rm).
- `SrcBE` in WIDTH: multiplier (Rs).
- `SrcCE` in WIDTH: accumulator (Ra), used only when `AccE` = 1.
- `MulResultE` out WIDTH: low WIDTH bits of A*B(+C).
- `MulValidE` out 1: result valid this cycle.
- `MulFlagsE` out 2: {N, Z} of `MulResultE`.
- `StallMulE` out 1: to the hazard unit; stalls F/D/E and bubbles M.
- `BusyE` out 1: state is BUSY.

## Operation
- States: IDLE, BUSY, DONE. Registers: `a` (WIDTH), `b` (WIDTH), `acc` (WIDTH), `cnt` (CNTW), `state`.
- **IDLE:**
  - If `StartE` and not `KillE`: load `a`=`SrcAE`, `b`=`SrcBE`, `acc` = `AccE` ? `SrcCE` : 0, `cnt`=0, then go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY (one iteration per cycle):**
  - If `b[0]`, then `acc` += `a` (mod 2^WIDTH).
  - Then `a` <<= 1, `b` >>= 1, `cnt`++.
  - Go to DONE when `cnt` = WIDTH-1, or on the early-termination condition described under Configuration.
- **DONE:**
  - `MulResultE` = `acc`, `MulValidE` = 1.
  - Next state is IDLE unconditionally. `StartE` is not sampled in DONE, because the pipeline advances that cycle.
- `StallMulE` = (IDLE & `StartE` & ~`KillE`) | BUSY. This is combinational and is low in DONE.
- `MulFlagsE` = {`acc[WIDTH-1]`, `acc`==0}. It is meaningful only while `MulValidE` = 1. C and V are not produced.
- **`KillE`:** in any state, forces next state to IDLE. `acc` is not updated and `MulValidE` stays 0 the following cycle.
- **`reset`:** in any state, including mid-BUSY, immediately sets state to IDLE, zeroes all registers and outputs, and drops `StallMulE`.
- **`StartE` while BUSY:** ignored; it is the same held instruction.
- **Back-to-back multiplies:** DONE → IDLE. The next `StartE` is sampled in that IDLE cycle, so there is no dead cycle beyond the IDLE cycle.
- **`MulResultE`:** holds the last `acc` value while in IDLE. Consumers use it only when `MulValidE` = 1.

## Timing
- `StartE` first seen in IDLE at cycle T: BUSY occupies T+1 … T+N, DONE at T+N+1.
- N = WIDTH (32) without early termination. With early termination, N = max(1, index of highest set bit of `SrcBE` + 1).
- `StallMulE` is high in cycles T … T+N; `MulValidE` is high only in T+N+1.
- Reset values:
  - state = IDLE
  - `MulResultE` = 0
  - `MulValidE` = 0
  - `MulFlagsE` = 2'b01 (Z set because `acc` = 0)
  - `StallMulE` = 0
  - `BusyE` = 0

## Configuration
- Macro `MUL_EARLY_TERM_EN`.
- **Defined:** BUSY also exits to DONE when the post-shift `b` = 0. Latency tracks the multiplier's bit-length; a minimum of 1 iteration is always performed.
- **Undefined:** fixed WIDTH iterations regardless of operands. The result is identical in both builds; only latency differs.

## Test plan
- MUL 7×6, `AccE`=0, `StartE` at T.
  - Expect `MulResultE`=42, `MulFlagsE`=00, `MulValidE` at T+33 (no macro) or T+4 (with macro).
- MLA 3×5+10.
  - Expect 25; `StallMulE` high exactly T … T+N.
- 0xFFFFFFFF × 0xFFFFFFFF, MUL.
  - Expect 0x00000001 (wrap to low 32 bits).
- 0x80000000 × 1, then 5 × 0.
  - First result 0x80000000 with N=1.
  - Second result 0 with Z=1; with the macro, DONE at T+2.
- `KillE` asserted at T+5 of a BUSY multiply.
  - Expect IDLE at T+6, no `MulValidE`, `StallMulE` low at T+6.
- `reset` pulsed asynchronously mid-BUSY.
  - Expect all outputs at reset values immediately.
  - A subsequent 2×2 MUL returns 4.
